// File: rtl/pio_in_edge.sv
// pio_in_edge: parallel input port with per-bit edge capture and a level
// interrupt, behind a small four-register bus slave.
//
// The external inputs pass through a two-flop synchroniser. The filtered
// value is then compared with its value one cycle earlier to find edges.
// Each detected edge latches a sticky bit in edge_capture. Software clears
// those bits by writing 1s to address 3. irq is the registered OR of
// (edge_capture & irq_mask).
//
// Register map:
//   0 data         (filtered inputs, read-only)
//   1 reserved     (reads 0, writes ignored)
//   2 irq_mask     (R/W)
//   3 edge_capture (read, write-1-to-clear)
//
// Optional feature: define PIO_IN_DEBOUNCE_EN to add a per-bit debounce
// filter. A bit of the filtered value follows its synchronised input only
// after the input has differed from it for DEBOUNCE_CYCLES consecutive
// cycles. Without the macro, the filtered value is the synchroniser output.
//
// Parameters:
//   WIDTH           number of input bits (1..32)
//   EDGE_TYPE       0 = rising, 1 = falling, 2 = any edge
//   DEBOUNCE_CYCLES stable-cycle count for the debounce filter (2..65535)
//
// Ports:
//   clk         clock, all logic on the rising edge
//   reset_n     asynchronous active-low reset
//   address     register select
//   chipselect  bus access qualifier
//   write_n     active-low write strobe
//   writedata   write data
//   in_port     asynchronous external inputs
//   readdata    registered read data, one cycle latency, 0 when not selected
//   irq         registered level interrupt, active-high
module pio_in_edge #(
  parameter int WIDTH           = 8,
  parameter int EDGE_TYPE       = 0,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [WIDTH-1:0] writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] readdata,
  output logic             irq
);

  // Elaboration-time parameter range checks.
  generate
    if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
      $error("pio_in_edge: WIDTH must be 1..32");
    end
    if (EDGE_TYPE < 0 || EDGE_TYPE > 2) begin : g_bad_edge_type
      $error("pio_in_edge: EDGE_TYPE must be 0, 1 or 2");
    end
    if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > 65535) begin : g_bad_debounce
      $error("pio_in_edge: DEBOUNCE_CYCLES must be 2..65535");
    end
  endgenerate

  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;
  logic [WIDTH-1:0] filt;
  logic [WIDTH-1:0] prev;
  logic [WIDTH-1:0] edge_det;
  logic [WIDTH-1:0] irq_mask;
  logic [WIDTH-1:0] edge_capture;
  logic [WIDTH-1:0] clr_bits;
  logic [WIDTH-1:0] rd_mux;
  logic [1:0]       arm_cnt;
  logic             armed;
  logic             wr_en;

  // Two-flop synchroniser for the asynchronous inputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= in_port;
      sync2 <= sync1;
    end
  end

`ifdef PIO_IN_DEBOUNCE_EN
  localparam logic [15:0] DB_LAST = 16'(DEBOUNCE_CYCLES - 1);

  logic [15:0] db_cnt [WIDTH];

  // A counter runs only while sync2 disagrees with filt. A single-bit input
  // that changes back returns to agreement, so that case also restarts the
  // count. filt takes the new value on the DEBOUNCE_CYCLES-th disagreeing
  // cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      filt <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        db_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (sync2[i] == filt[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          filt[i]   <= sync2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 16'd1;
        end
      end
    end
  end
`else
  assign filt = sync2;
`endif

  // prev lags filt by one cycle. The arm counter keeps edge detection off
  // until the synchroniser has filled after reset release, so inputs held
  // high through reset do not look like a rising edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev    <= '0;
      arm_cnt <= '0;
    end else begin
      prev <= filt;
      if (arm_cnt != 2'd3) begin
        arm_cnt <= arm_cnt + 2'd1;
      end
    end
  end

  assign armed = (arm_cnt == 2'd3);

  always_comb begin
    edge_det = '0;
    if (armed) begin
      case (EDGE_TYPE)
        0:       edge_det = filt & ~prev;
        1:       edge_det = ~filt & prev;
        default: edge_det = filt ^ prev;
      endcase
    end
  end

  assign wr_en    = chipselect && !write_n;
  assign clr_bits = (wr_en && address == 2'd3) ? writedata : '0;

  always_comb begin
    rd_mux = '0;
    if (chipselect) begin
      case (address)
        2'd0:    rd_mux = filt;
        2'd2:    rd_mux = irq_mask;
        2'd3:    rd_mux = edge_capture;
        default: rd_mux = '0;
      endcase
    end
  end

  // A set from a new edge is OR-ed in after the clear, so it wins when both
  // hit the same bit in the same cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_mask     <= '0;
      edge_capture <= '0;
      irq          <= 1'b0;
      readdata     <= '0;
    end else begin
      if (wr_en && address == 2'd2) begin
        irq_mask <= writedata;
      end
      edge_capture <= (edge_capture & ~clr_bits) | edge_det;
      irq          <= |(edge_capture & irq_mask);
      readdata     <= rd_mux;
    end
  end

endmodule
